// File: rtl/dot_product_sequencer.sv
// Sequences paired reads of two Q16.16 vectors and accumulates their dot product.
// Read data returns one cycle after each strobe; the sum is published when the operation completes.
module dot_product_sequencer #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] b_base,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr_a,
    output logic [ADDR_W-1:0] mem_addr_b,
    input  logic [31:0]       mem_rdata_a,
    input  logic [31:0]       mem_rdata_b,
    output logic              busy,
    output logic              done,
    output logic [31:0]       result
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                w_accept;
    logic [LEN_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_addr_a;
    logic [ADDR_W-1:0]   r_addr_b;
    logic                r_rd_q;
    logic [31:0]         r_acc;
    logic [31:0]         r_result;
    logic signed [63:0]  w_a_ext;
    logic signed [63:0]  w_b_ext;
    logic signed [63:0]  w_prod_full;
    logic [31:0]         w_prod;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Full-width signed product; bits [47:16] give the Q16.16 result rounded toward minus infinity.
    assign w_a_ext     = {{32{mem_rdata_a[31]}}, mem_rdata_a};
    assign w_b_ext     = {{32{mem_rdata_b[31]}}, mem_rdata_b};
    assign w_prod_full = w_a_ext * w_b_ext;
    assign w_prod      = 32'(w_prod_full >> 16);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_next_state = (len == '0) ? S_DONE : S_ISSUE;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (r_cnt == '0) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: w_next_state = S_DONE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        mem_rd     = 1'b0;
        mem_addr_a = '0;
        mem_addr_b = '0;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            S_ISSUE: begin
                mem_rd     = 1'b1;
                mem_addr_a = r_addr_a;
                mem_addr_b = r_addr_b;
                busy       = 1'b1;
            end
            S_DRAIN: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // r_rd_q marks the cycle a read returns; it is cleared by reset so late data is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_addr_a <= '0;
            r_addr_b <= '0;
            r_rd_q   <= 1'b0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            r_rd_q <= (r_state == S_ISSUE);
            if (w_accept) begin
                r_cnt    <= len - LEN_W'(1);
                r_addr_a <= a_base;
                r_addr_b <= b_base;
                r_acc    <= '0;
                r_result <= '0;
            end else begin
                if (r_state == S_ISSUE) begin
                    r_cnt    <= r_cnt - LEN_W'(1);
                    r_addr_a <= r_addr_a + ADDR_W'(1);
                    r_addr_b <= r_addr_b + ADDR_W'(1);
                end
                if (r_rd_q) begin
                    r_acc <= r_acc + w_prod;
                end
                if ((r_state == S_DRAIN) && r_rd_q) begin
                    r_result <= r_acc + w_prod;
                end
            end
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed bench for dot_product_sequencer: memory model with one-cycle read latency,
// hand-computed Q16.16 results, latency, address wrap, ignored start and reset abort.
module tb_dot_product_sequencer;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned LEN_W  = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] a_base;
    logic [ADDR_W-1:0] b_base;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr_a;
    logic [ADDR_W-1:0] mem_addr_b;
    logic [31:0]       mem_rdata_a;
    logic [31:0]       mem_rdata_b;
    logic              busy;
    logic              done;
    logic [31:0]       result;

    logic [31:0] mem_a [0:(1<<ADDR_W)-1];
    logic [31:0] mem_b [0:(1<<ADDR_W)-1];

    int n_checks = 0;
    int n_errors = 0;

    dot_product_sequencer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .len         (len),
        .a_base      (a_base),
        .b_base      (b_base),
        .mem_rd      (mem_rd),
        .mem_addr_a  (mem_addr_a),
        .mem_addr_b  (mem_addr_b),
        .mem_rdata_a (mem_rdata_a),
        .mem_rdata_b (mem_rdata_b),
        .busy        (busy),
        .done        (done),
        .result      (result)
    );

    always #5 clk = ~clk;

    // Read data valid one cycle after the strobe; junk otherwise so stray accumulation shows up.
    always @(posedge clk) begin
        if (mem_rd) begin
            mem_rdata_a <= mem_a[mem_addr_a];
            mem_rdata_b <= mem_b[mem_addr_b];
        end else begin
            mem_rdata_a <= 32'hDEAD_BEEF;
            mem_rdata_b <= 32'h1234_5678;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic start_op(input int n, input logic [ADDR_W-1:0] ab, input logic [ADDR_W-1:0] bb);
        start  = 1'b1;
        len    = LEN_W'(n);
        a_base = ab;
        b_base = bb;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Starts an operation from the current negedge and returns at the negedge of the done cycle.
    task automatic run_op(input string tag, input int n, input logic [ADDR_W-1:0] ab,
                          input logic [ADDR_W-1:0] bb, input logic [31:0] exp_res, input bit poke);
        int rd_cnt;
        int done_cyc;
        logic [ADDR_W-1:0] ea;
        logic [ADDR_W-1:0] eb;
        rd_cnt   = 0;
        done_cyc = -1;
        start_op(n, ab, bb);
        for (int k = 1; k <= 40 && done_cyc < 0; k++) begin
            if (mem_rd) begin
                ea = ab + ADDR_W'(rd_cnt);
                eb = bb + ADDR_W'(rd_cnt);
                check({tag, " addr_a"}, 32'(mem_addr_a), 32'(ea));
                check({tag, " addr_b"}, 32'(mem_addr_b), 32'(eb));
                rd_cnt++;
            end else begin
                check({tag, " idle_addr"}, 32'({mem_addr_a, mem_addr_b}), 32'h0);
            end
            if (done) done_cyc = k;
            if (poke && k == 1) begin
                start  = 1'b1;
                len    = LEN_W'(7);
                a_base = '0;
                b_base = '0;
            end else begin
                start = 1'b0;
            end
            if (done_cyc < 0) @(negedge clk);
        end
        check({tag, " rd_cycles"}, 32'(rd_cnt), 32'(n));
        check({tag, " done_cycle"}, 32'(done_cyc), (n == 0) ? 32'd1 : 32'(n + 2));
        check({tag, " result"}, result, exp_res);
        check({tag, " busy_in_done"}, 32'(busy), 32'h0);
    endtask

    task automatic idle_after(input string tag, input logic [31:0] exp_res);
        @(negedge clk);
        check({tag, " done_drop"}, 32'(done), 32'h0);
        check({tag, " busy_idle"}, 32'(busy), 32'h0);
        check({tag, " result_held"}, result, exp_res);
    endtask

    initial begin
        int n_done;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        // 3-element vector: 1*3 + 2*0.5 + (-0.5)*4 = 2.0
        mem_a[16] = 32'h0001_0000; mem_a[17] = 32'h0002_0000; mem_a[18] = 32'hFFFF_8000;
        mem_b[32] = 32'h0003_0000; mem_b[33] = 32'h0000_8000; mem_b[34] = 32'h0004_0000;
        mem_a[48] = 32'h0000_0001; mem_b[64] = 32'hFFFF_FFFF;
        mem_a[80] = 32'h7FFF_0000; mem_a[81] = 32'h7FFF_0000;
        mem_b[96] = 32'h0001_0000; mem_b[97] = 32'h0001_0000;
        // Wrapping A addresses: 2*1 + 3*2 = 8.0
        mem_a[1023] = 32'h0002_0000; mem_a[0] = 32'h0003_0000;
        mem_b[256]  = 32'h0001_0000; mem_b[257] = 32'h0002_0000;

        rst = 1'b1; start = 1'b0; len = '0; a_base = '0; b_base = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'h0);
        check("reset done", 32'(done), 32'h0);
        check("reset mem_rd", 32'(mem_rd), 32'h0);
        check("reset result", result, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        run_op("vec3", 3, 10'd16, 10'd32, 32'h0002_0000, 1'b0);
        // Start accepted while in DONE; timing counts from that edge
        run_op("floor", 1, 10'd48, 10'd64, 32'hFFFF_FFFF, 1'b0);
        idle_after("floor", 32'hFFFF_FFFF);
        run_op("wrap", 2, 10'd80, 10'd96, 32'hFFFE_0000, 1'b0);
        idle_after("wrap", 32'hFFFE_0000);
        run_op("zero", 0, 10'd16, 10'd32, 32'h0, 1'b0);
        idle_after("zero", 32'h0);
        run_op("addrwrap", 2, 10'd1023, 10'd256, 32'h0008_0000, 1'b1);
        idle_after("addrwrap", 32'h0008_0000);

        // Reset in the second ISSUE cycle, with start also high to check reset priority
        start_op(5, 10'd16, 10'd32);
        @(negedge clk);
        rst = 1'b1; start = 1'b1; len = LEN_W'(3);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("abort busy", 32'(busy), 32'h0);
        check("abort done", 32'(done), 32'h0);
        check("abort mem_rd", 32'(mem_rd), 32'h0);
        check("abort addr", 32'({mem_addr_a, mem_addr_b}), 32'h0);
        check("abort result", result, 32'h0);
        n_done = 0;
        for (int k = 0; k < 8; k++) begin
            if (done || busy) n_done++;
            @(negedge clk);
        end
        check("abort no_done", 32'(n_done), 32'h0);
        run_op("after_rst", 3, 10'd16, 10'd32, 32'h0002_0000, 1'b0);
        idle_after("after_rst", 32'h0002_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dot_product_sequencer.md
DOT_PRODUCT_SEQUENCER -- requirements
Module: dot_product_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, memory address width.
REQ-002 SHALL have parameter LEN_W, default 10, vector length width.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request a dot product; sampled on clk.
REQ-007 len  input  LEN_W  element count N, unsigned; sampled with start.
REQ-008 a_base  input  ADDR_W  vector A base address; sampled with start.
REQ-009 b_base  input  ADDR_W  vector B base address; sampled with start.
REQ-010 mem_rd  output  1  read strobe, shared by both vector ports.
REQ-011 mem_addr_a  output  ADDR_W  vector A read address.
REQ-012 mem_addr_b  output  ADDR_W  vector B read address.
REQ-013 mem_rdata_a  input  32  A element in Q16.16; valid exactly one cycle after mem_rd.
REQ-014 mem_rdata_b  input  32  B element in Q16.16; valid exactly one cycle after mem_rd.
REQ-015 busy  output  1  high in ISSUE and DRAIN.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 result  output  32  Q16.16 dot product; held until the next accepted start.

Function
REQ-018 SHALL implement states IDLE, ISSUE, DRAIN, DONE.
REQ-019 Accept: start high at edge E0 while in IDLE or DONE; latch len, a_base, b_base; clear accumulator and result to 0.
REQ-020 start high in ISSUE or DRAIN SHALL be ignored, with no effect on the operation in progress.
REQ-021 N>0: go to ISSUE; mem_rd high for exactly the N cycles after E0; in cycle i (0..N-1), mem_addr_a = a_base+i and mem_addr_b = b_base+i, both modulo 2^ADDR_W.
REQ-022 After the last issue cycle: one DRAIN cycle, then DONE for exactly one cycle with done=1, then IDLE unless a new start is accepted.
REQ-023 Latency: done SHALL be high in the (N+2)th cycle after E0; result is valid in that same cycle.
REQ-024 N=0: no mem_rd; done high in the cycle immediately after E0; result=0.
REQ-025 Each product: sign-extend both operands to 64 bits, multiply, take product bits [47:16] (Q16.16, truncation toward minus infinity).
REQ-026 Accumulate with 32-bit two's-complement add; overflow wraps modulo 2^32, with no saturation and no flag.
REQ-027 Accumulate read data only on the cycle after mem_rd; ignore mem_rdata at all other times.
REQ-028 Outside ISSUE, mem_rd=0 and mem_addr_a/b=0.
REQ-029 Start accepted in DONE: behaves as in REQ-019; done still pulses in that cycle; the next operation's timing counts from that edge.

Reset
REQ-030 rst high at an edge: next cycle state=IDLE and accumulator=0; busy=0, done=0, mem_rd=0, mem_addr_a=0, mem_addr_b=0, result=0.
REQ-031 Reset mid-operation: abort with no done pulse; read data returning after reset is ignored.
REQ-032 rst has priority over start in the same cycle.

Verification
REQ-033 A=[0x00010000,0x00020000,0xFFFF8000], B=[0x00030000,0x00008000,0x00040000], N=3 -> mem_rd high 3 cycles, done in cycle 5 after E0, result=0x00020000.
REQ-034 N=1, A=0x00000001, B=0xFFFFFFFF -> result=0xFFFFFFFF (floor truncation).
REQ-035 N=2, A=B'=[0x7FFF0000,0x7FFF0000], B=[0x00010000,0x00010000] -> result=0xFFFE0000 (wrap).
REQ-036 N=0 -> no mem_rd, done in cycle 1 after E0, result=0.
REQ-037 a_base=2^ADDR_W-1, N=2 -> mem_addr_a sequence 0x3FF, 0x000; start pulsed mid-ISSUE is ignored.
REQ-038 rst asserted in 2nd ISSUE cycle of N=5 -> no done pulse, all outputs 0 next cycle; new start then completes correctly.
